// File: rtl/ddr3_req_arbiter_pkg.sv
// Shared types and constants for the DDR3 write/read request arbiter.
// Direction encoding doubles as the cmd_write_o value.
package ddr3_req_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WR_SEQ = 2'd1,
    ST_RD_SEQ = 2'd2
  } arb_state_t;

  localparam logic DIR_RD = 1'b0;
  localparam logic DIR_WR = 1'b1;

  // Starvation counter must hold 0..limit, never narrower than one bit.
  function automatic int starve_width(input int limit);
    int w;
    w = $clog2(limit + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/ddr3_req_arbiter.sv
// Merges the AXI write- and read-request ports into one registered DDR3 command
// stream: atomic multi-command sequences, read preference with bounded write starvation.
module ddr3_req_arbiter
  import ddr3_req_arbiter_pkg::*;
#(
  parameter int ADDRS           = 32,
  parameter int MEM_ID_WIDTH    = 4,
  parameter int TURN_CYCLES     = 2,
  parameter int WR_STARVE_LIMIT = 4
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    wr_req_i,
  output logic                    wr_ack_o,
  input  logic                    wr_lst_i,
  input  logic [MEM_ID_WIDTH-1:0] wr_tid_i,
  input  logic [ADDRS-1:0]        wr_adr_i,
  input  logic                    rd_req_i,
  output logic                    rd_ack_o,
  input  logic                    rd_lst_i,
  input  logic [MEM_ID_WIDTH-1:0] rd_tid_i,
  input  logic [ADDRS-1:0]        rd_adr_i,
  output logic                    cmd_valid_o,
  input  logic                    cmd_ready_i,
  output logic                    cmd_write_o,
  output logic                    cmd_last_o,
  output logic [MEM_ID_WIDTH-1:0] cmd_tid_o,
  output logic [ADDRS-1:0]        cmd_addr_o,
  output logic                    busy_o
);

  localparam int              SW         = starve_width(WR_STARVE_LIMIT);
  localparam logic [SW-1:0]   STARVE_MAX = SW'(WR_STARVE_LIMIT);
  localparam logic [3:0]      TURN_LOAD  = 4'(TURN_CYCLES);

  arb_state_t              r_state;
  logic                    r_last_dir;
  logic [3:0]              r_turn_cnt;
  logic [SW-1:0]           r_starve_cnt;
  logic                    r_cmd_valid;
  logic                    r_cmd_write;
  logic                    r_cmd_last;
  logic [MEM_ID_WIDTH-1:0] r_cmd_tid;
  logic [ADDRS-1:0]        r_cmd_addr;

  logic w_room;
  logic w_accept;
  logic w_elig_wr;
  logic w_elig_rd;
  logic w_pref_wr;
  logic w_grant_wr;
  logic w_grant_rd;
  logic w_ack_wr;
  logic w_ack_rd;
  logic w_load;

  assign w_room    = ~r_cmd_valid | cmd_ready_i;
  assign w_accept  = r_cmd_valid & cmd_ready_i;
  // Reversing direction waits for the turnaround gap and an empty command register.
  assign w_elig_wr = (r_last_dir == DIR_WR) | ((r_turn_cnt == 4'd0) & ~r_cmd_valid);
  assign w_elig_rd = (r_last_dir == DIR_RD) | ((r_turn_cnt == 4'd0) & ~r_cmd_valid);

  generate
    if (WR_STARVE_LIMIT == 0) begin : g_wr_always
      assign w_pref_wr = 1'b1;
    end else begin : g_wr_bounded
      assign w_pref_wr = (r_starve_cnt >= STARVE_MAX);
    end
  endgenerate

  always_comb begin
    w_grant_wr = 1'b0;
    w_grant_rd = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (wr_req_i && rd_req_i) begin
          if (w_pref_wr) begin
            w_grant_wr = w_elig_wr;
          end else begin
            w_grant_rd = w_elig_rd;
          end
        end else if (wr_req_i) begin
          w_grant_wr = w_elig_wr;
        end else if (rd_req_i) begin
          w_grant_rd = w_elig_rd;
        end else begin
          w_grant_wr = 1'b0;
          w_grant_rd = 1'b0;
        end
      end
      ST_WR_SEQ: w_grant_wr = 1'b1;
      ST_RD_SEQ: w_grant_rd = 1'b1;
      default: begin
        w_grant_wr = 1'b0;
        w_grant_rd = 1'b0;
      end
    endcase
  end

  assign w_ack_wr = wr_req_i & w_grant_wr & w_room;
  assign w_ack_rd = rd_req_i & w_grant_rd & w_room;
  assign w_load   = w_ack_wr | w_ack_rd;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_cmd_valid <= 1'b0;
      r_cmd_write <= 1'b0;
      r_cmd_last  <= 1'b0;
      r_cmd_tid   <= '0;
      r_cmd_addr  <= '0;
      r_last_dir  <= DIR_RD;
    end else if (w_load) begin
      r_cmd_valid <= 1'b1;
      r_cmd_write <= w_ack_wr;
      r_cmd_last  <= w_ack_wr ? wr_lst_i : rd_lst_i;
      r_cmd_tid   <= w_ack_wr ? wr_tid_i : rd_tid_i;
      r_cmd_addr  <= w_ack_wr ? wr_adr_i : rd_adr_i;
      r_last_dir  <= w_ack_wr ? DIR_WR : DIR_RD;
    end else if (w_accept) begin
      r_cmd_valid <= 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_turn_cnt   <= 4'd0;
      r_starve_cnt <= '0;
    end else begin
      if (w_accept) begin
        r_turn_cnt <= TURN_LOAD;
      end else if (r_turn_cnt != 4'd0) begin
        r_turn_cnt <= r_turn_cnt - 4'd1;
      end
      // Only completed read sequences count against a waiting write.
      if (w_ack_wr && wr_lst_i) begin
        r_starve_cnt <= '0;
      end else if (w_ack_rd && rd_lst_i && wr_req_i && (r_starve_cnt != STARVE_MAX)) begin
        r_starve_cnt <= r_starve_cnt + SW'(1);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_ack_wr && !wr_lst_i) begin
            r_state <= ST_WR_SEQ;
          end else if (w_ack_rd && !rd_lst_i) begin
            r_state <= ST_RD_SEQ;
          end
        end
        ST_WR_SEQ: if (w_ack_wr && wr_lst_i) r_state <= ST_IDLE;
        ST_RD_SEQ: if (w_ack_rd && rd_lst_i) r_state <= ST_IDLE;
        default:   r_state <= ST_IDLE;
      endcase
    end
  end

  assign wr_ack_o    = w_ack_wr;
  assign rd_ack_o    = w_ack_rd;
  assign cmd_valid_o = r_cmd_valid;
  assign cmd_write_o = r_cmd_write;
  assign cmd_last_o  = r_cmd_last;
  assign cmd_tid_o   = r_cmd_tid;
  assign cmd_addr_o  = r_cmd_addr;
  assign busy_o      = (r_state != ST_IDLE) | r_cmd_valid | (r_turn_cnt != 4'd0);

`ifdef __icarus
  ddr3_req_arbiter_chk #(.ADDRS(ADDRS), .MEM_ID_WIDTH(MEM_ID_WIDTH)) u_wr_chk (
    .clock(clock), .reset(reset), .i_req(wr_req_i), .i_ack(w_ack_wr),
    .i_lst(wr_lst_i), .i_tid(wr_tid_i), .i_adr(wr_adr_i)
  );
  ddr3_req_arbiter_chk #(.ADDRS(ADDRS), .MEM_ID_WIDTH(MEM_ID_WIDTH)) u_rd_chk (
    .clock(clock), .reset(reset), .i_req(rd_req_i), .i_ack(w_ack_rd),
    .i_lst(rd_lst_i), .i_tid(rd_tid_i), .i_adr(rd_adr_i)
  );
`endif

endmodule

`ifdef __icarus
// A pending, unacked request must hold req and keep its fields stable.
module ddr3_req_arbiter_chk #(
  parameter int ADDRS        = 32,
  parameter int MEM_ID_WIDTH = 4
) (
  input logic                    clock,
  input logic                    reset,
  input logic                    i_req,
  input logic                    i_ack,
  input logic                    i_lst,
  input logic [MEM_ID_WIDTH-1:0] i_tid,
  input logic [ADDRS-1:0]        i_adr
);
  logic                    r_pend;
  logic                    r_lst;
  logic [MEM_ID_WIDTH-1:0] r_tid;
  logic [ADDRS-1:0]        r_adr;

  always_ff @(posedge clock) begin
    if (!reset && r_pend && (!i_req || (i_lst != r_lst) || (i_tid != r_tid) || (i_adr != r_adr))) begin
      $fatal(1, "request dropped or changed while pending");
    end
    r_pend <= ~reset & i_req & ~i_ack;
    r_lst  <= i_lst;
    r_tid  <= i_tid;
    r_adr  <= i_adr;
  end
endmodule
`endif
